// File: rtl/alu_operand_stage_pkg.sv
// Shared opcode / function-code constants, the bubble encoding and the
// per-opcode source-usage table for the ID/EX operand stage.
package alu_operand_stage_pkg;

   typedef enum logic [6:0] {
      OPC_LOAD   = 7'b0000011,
      OPC_OP_IMM = 7'b0010011,
      OPC_AUIPC  = 7'b0010111,
      OPC_STORE  = 7'b0100011,
      OPC_OP     = 7'b0110011,
      OPC_LUI    = 7'b0110111,
      OPC_BRANCH = 7'b1100011,
      OPC_JALR   = 7'b1100111,
      OPC_JAL    = 7'b1101111
   } opcode_e;

   localparam logic [2:0] FNC_ADD_SUB = 3'b000;
   localparam logic [2:0] FNC_SR      = 3'b101;
   localparam logic       FNC2_ADD    = 1'b0;
   localparam logic       FNC2_SUB    = 1'b1;

   // All-zero opcode decodes as "unknown", so a bubble drives ADD with zero operands.
   localparam logic [6:0] OPC_BUBBLE  = 7'b0000000;

   typedef struct packed {
      logic rs1;
      logic rs2;
   } src_use_t;

   function automatic src_use_t src_use(input logic [6:0] opcode);
      src_use_t u;
      u = '{rs1: 1'b0, rs2: 1'b0};
      case (opcode)
         OPC_OP, OPC_BRANCH, OPC_STORE: u = '{rs1: 1'b1, rs2: 1'b1};
         OPC_OP_IMM, OPC_LOAD, OPC_JALR: u = '{rs1: 1'b1, rs2: 1'b0};
         default: u = '{rs1: 1'b0, rs2: 1'b0};
      endcase
      return u;
   endfunction

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Per-source operand forwarding: MEM (final results only) over WB over regfile.
// With ALU_OPERAND_FWD_EN undefined the mux collapses to the registered data.
module operand_fwd_mux #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] idx,
   input  logic [XLEN-1:0]   reg_data,
   input  logic              mem_rd_we,
   input  logic [REG_AW-1:0] mem_rd_addr,
   input  logic [XLEN-1:0]   mem_result,
   input  logic              mem_result_ok,
   input  logic              wb_rd_we,
   input  logic [REG_AW-1:0] wb_rd_addr,
   input  logic [XLEN-1:0]   wb_result,
   output logic [XLEN-1:0]   fwd_data
);

`ifdef ALU_OPERAND_FWD_EN
   always_comb begin
      if (idx == '0)
         fwd_data = '0;
      else if (mem_rd_we && mem_rd_addr == idx && mem_result_ok)
         fwd_data = mem_result;
      else if (wb_rd_we && wb_rd_addr == idx)
         fwd_data = wb_result;
      else
         fwd_data = reg_data;
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{mem_rd_we, mem_rd_addr, mem_result, mem_result_ok,
                         wb_rd_we, wb_rd_addr, wb_result};
   assign fwd_data   = (idx == '0) ? '0 : reg_data;
`endif

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX stage feeding alu_module: handshake capture, load-use hazard, flush,
// operand/function select. Forwarding is enabled by ALU_OPERAND_FWD_EN.
module alu_operand_stage
   import alu_operand_stage_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [6:0]        id_opcode,
   input  logic [2:0]        id_fnc3,
   input  logic              id_f7b5,
   input  logic [REG_AW-1:0] id_rs1_addr,
   input  logic [REG_AW-1:0] id_rs2_addr,
   input  logic [REG_AW-1:0] id_rd_addr,
   input  logic [XLEN-1:0]   id_rs1_data,
   input  logic [XLEN-1:0]   id_rs2_data,
   input  logic [XLEN-1:0]   id_imm,
   input  logic              mem_rd_we,
   input  logic [REG_AW-1:0] mem_rd_addr,
   input  logic [XLEN-1:0]   mem_result,
   input  logic              mem_result_ok,
   input  logic              wb_rd_we,
   input  logic [REG_AW-1:0] wb_rd_addr,
   input  logic [XLEN-1:0]   wb_result,
   input  logic              ex_stall,
   input  logic              flush,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_in_A,
   output logic [XLEN-1:0]   ex_in_B,
   output logic [2:0]        ex_fnc3,
   output logic              ex_fnc2,
   output logic [REG_AW-1:0] ex_rd_addr,
   output logic              ex_rd_we,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_rs2_fwd
);

   typedef struct packed {
      logic              valid;
      logic [XLEN-1:0]   pc;
      logic [6:0]        opcode;
      logic [2:0]        fnc3;
      logic              f7b5;
      logic [REG_AW-1:0] rs1_addr;
      logic [REG_AW-1:0] rs2_addr;
      logic [REG_AW-1:0] rd_addr;
      logic [XLEN-1:0]   rs1_data;
      logic [XLEN-1:0]   rs2_data;
      logic [XLEN-1:0]   imm;
   } stage_t;

   localparam stage_t BUBBLE = '{opcode: OPC_BUBBLE, default: '0};

   stage_t    q, d;
   src_use_t  use_q;
   logic      hazard, hold;
   logic      rd_we_raw;
   logic [XLEN-1:0] rs1_fwd, rs2_fwd;

   assign use_q = src_use(q.opcode);

`ifdef ALU_OPERAND_FWD_EN
   // Only an in-flight load (result not yet final) can stall; everything else forwards.
   assign hazard = q.valid && mem_rd_we && mem_rd_addr != '0 && !mem_result_ok &&
                   ((use_q.rs1 && mem_rd_addr == q.rs1_addr) ||
                    (use_q.rs2 && mem_rd_addr == q.rs2_addr));
`else
   logic mem_hit, wb_hit;
   assign mem_hit = mem_rd_we && mem_rd_addr != '0 &&
                    ((use_q.rs1 && mem_rd_addr == q.rs1_addr) ||
                     (use_q.rs2 && mem_rd_addr == q.rs2_addr));
   assign wb_hit  = wb_rd_we && wb_rd_addr != '0 &&
                    ((use_q.rs1 && wb_rd_addr == q.rs1_addr) ||
                     (use_q.rs2 && wb_rd_addr == q.rs2_addr));
   assign hazard  = q.valid && (mem_hit || wb_hit);
`endif

   assign hold     = ex_stall || hazard;
   assign id_ready = !hold || flush;

   always_comb begin
      d = q;
      if (flush)
         d = BUBBLE;
      else if (hold)
         d = q;
      else if (id_valid)
         d = '{valid: 1'b1, pc: id_pc, opcode: id_opcode, fnc3: id_fnc3,
               f7b5: id_f7b5, rs1_addr: id_rs1_addr, rs2_addr: id_rs2_addr,
               rd_addr: id_rd_addr, rs1_data: id_rs1_data,
               rs2_data: id_rs2_data, imm: id_imm};
      else
         d = BUBBLE;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q <= BUBBLE;
      else
         q <= d;
   end

   operand_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
      .idx(q.rs1_addr), .reg_data(q.rs1_data),
      .mem_rd_we(mem_rd_we), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
      .mem_result_ok(mem_result_ok), .wb_rd_we(wb_rd_we), .wb_rd_addr(wb_rd_addr),
      .wb_result(wb_result), .fwd_data(rs1_fwd)
   );

   operand_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
      .idx(q.rs2_addr), .reg_data(q.rs2_data),
      .mem_rd_we(mem_rd_we), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
      .mem_result_ok(mem_result_ok), .wb_rd_we(wb_rd_we), .wb_rd_addr(wb_rd_addr),
      .wb_result(wb_result), .fwd_data(rs2_fwd)
   );

   // NOTE: every output of this block is defaulted first so no path infers a latch.
   always_comb begin
      ex_in_A   = '0;
      ex_in_B   = '0;
      ex_fnc3   = FNC_ADD_SUB;
      ex_fnc2   = FNC2_ADD;
      rd_we_raw = 1'b0;
      case (q.opcode)
         OPC_OP: begin
            ex_in_A = rs1_fwd;  ex_in_B = rs2_fwd;
            ex_fnc3 = q.fnc3;   ex_fnc2 = q.f7b5;
            rd_we_raw = 1'b1;
         end
         OPC_OP_IMM: begin
            ex_in_A = rs1_fwd;  ex_in_B = q.imm;
            ex_fnc3 = q.fnc3;   ex_fnc2 = (q.fnc3 == FNC_SR) ? q.f7b5 : FNC2_ADD;
            rd_we_raw = 1'b1;
         end
         OPC_LOAD, OPC_JALR: begin
            ex_in_A = rs1_fwd;  ex_in_B = q.imm;  rd_we_raw = 1'b1;
         end
         OPC_STORE: begin
            ex_in_A = rs1_fwd;  ex_in_B = q.imm;
         end
         OPC_LUI: begin
            ex_in_B = q.imm;    rd_we_raw = 1'b1;
         end
         OPC_AUIPC, OPC_JAL: begin
            ex_in_A = q.pc;     ex_in_B = q.imm;  rd_we_raw = 1'b1;
         end
         OPC_BRANCH: begin
            ex_in_A = q.pc;     ex_in_B = q.imm;
         end
         default: ;
      endcase
   end

   assign ex_valid   = q.valid && !hazard;
   assign ex_rd_we   = ex_valid && rd_we_raw && q.rd_addr != '0;
   assign ex_rd_addr = q.rd_addr;
   assign ex_pc      = q.pc;
   assign ex_rs2_fwd = rs2_fwd;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage; expectations follow ALU_OPERAND_FWD_EN.
module tb_alu_operand_stage;
   import alu_operand_stage_pkg::*;

   logic        clk, rst_n;
   logic        id_valid, id_ready;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [6:0]  id_opcode;
   logic [2:0]  id_fnc3;
   logic        id_f7b5;
   logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic        mem_rd_we, mem_result_ok, wb_rd_we;
   logic [4:0]  mem_rd_addr, wb_rd_addr;
   logic [31:0] mem_result, wb_result;
   logic        ex_stall, flush;
   logic        ex_valid, ex_fnc2, ex_rd_we;
   logic [31:0] ex_in_A, ex_in_B, ex_pc, ex_rs2_fwd;
   logic [2:0]  ex_fnc3;
   logic [4:0]  ex_rd_addr;

   int n_checks = 0;
   int n_fail   = 0;

   alu_operand_stage #(.XLEN(32), .REG_AW(5)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
      .id_pc(id_pc), .id_opcode(id_opcode), .id_fnc3(id_fnc3), .id_f7b5(id_f7b5),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .mem_rd_we(mem_rd_we), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
      .mem_result_ok(mem_result_ok), .wb_rd_we(wb_rd_we), .wb_rd_addr(wb_rd_addr),
      .wb_result(wb_result), .ex_stall(ex_stall), .flush(flush),
      .ex_valid(ex_valid), .ex_in_A(ex_in_A), .ex_in_B(ex_in_B), .ex_fnc3(ex_fnc3),
      .ex_fnc2(ex_fnc2), .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we),
      .ex_pc(ex_pc), .ex_rs2_fwd(ex_rs2_fwd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic [31:0] d1, input logic [31:0] d2,
                      input logic [31:0] imm, input logic [31:0] pc);
      id_valid = 1'b1;  id_opcode = opc;  id_fnc3 = f3;  id_f7b5 = f7;
      id_rs1_addr = rs1;  id_rs2_addr = rs2;  id_rd_addr = rd;
      id_rs1_data = d1;   id_rs2_data = d2;   id_imm = imm;  id_pc = pc;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;  id_valid = 1'b0;
      id_pc = '0; id_opcode = '0; id_fnc3 = '0; id_f7b5 = 1'b0;
      id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
      id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
      mem_rd_we = 1'b0; mem_rd_addr = '0; mem_result = '0; mem_result_ok = 1'b1;
      wb_rd_we = 1'b0; wb_rd_addr = '0; wb_result = '0;
      ex_stall = 1'b0; flush = 1'b0;

      // Reset state
      #3;
      check("rst_valid", ex_valid, 0);
      check("rst_rd_we", ex_rd_we, 0);
      check("rst_rd_addr", ex_rd_addr, 0);
      check("rst_pc", ex_pc, 0);
      check("rst_fnc3", ex_fnc3, FNC_ADD_SUB);
      check("rst_fnc2", ex_fnc2, 0);
      check("rst_A", ex_in_A, 0);
      check("rst_B", ex_in_B, 0);
      check("rst_rs2fwd", ex_rs2_fwd, 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      #1 check("rst_ready", id_ready, 1);
      tick();

      // ADD x3,x1,x2
      put(OPC_OP, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 32'h10);
      tick();  id_valid = 1'b0;  #1;
      check("add_valid", ex_valid, 1);
      check("add_A", ex_in_A, 5);
      check("add_B", ex_in_B, 7);
      check("add_fnc3", ex_fnc3, 0);
      check("add_fnc2", ex_fnc2, 0);
      check("add_rd_we", ex_rd_we, 1);
      check("add_rd_addr", ex_rd_addr, 3);

      // SUB x4,x1,x2 with MEM and WB both producing x1
      put(OPC_OP, 3'b000, 1'b1, 5'd1, 5'd2, 5'd4, 32'd1, 32'd2, 32'd0, 32'h14);
      tick();  id_valid = 1'b0;
      mem_rd_we = 1'b1; mem_rd_addr = 5'd1; mem_result = 32'h20; mem_result_ok = 1'b1;
      wb_rd_we  = 1'b1; wb_rd_addr  = 5'd1; wb_result  = 32'h10;
      #1;
`ifdef ALU_OPERAND_FWD_EN
      check("sub_mem_wins_A", ex_in_A, 32'h20);
      check("sub_valid", ex_valid, 1);
      check("sub_B", ex_in_B, 2);
      check("sub_fnc2", ex_fnc2, 1);
`else
      check("sub_haz_valid", ex_valid, 0);
      check("sub_haz_ready", id_ready, 0);
      check("sub_nofwd_A", ex_in_A, 1);
`endif
      mem_rd_we = 1'b0;  #1;
`ifdef ALU_OPERAND_FWD_EN
      check("sub_wb_A", ex_in_A, 32'h10);
`else
      check("sub_wb_haz_valid", ex_valid, 0);
`endif
      wb_rd_we = 1'b0;  #1;
      check("sub_reg_A", ex_in_A, 1);
      check("sub_reg_valid", ex_valid, 1);

      // SUB x0,x0,x2 with producers targeting x0
      put(OPC_OP, 3'b000, 1'b1, 5'd0, 5'd2, 5'd0, 32'h55, 32'd2, 32'd0, 32'h18);
      tick();  id_valid = 1'b0;
      mem_rd_we = 1'b1; mem_rd_addr = 5'd0; mem_result = 32'h20;
      wb_rd_we  = 1'b1; wb_rd_addr  = 5'd0; wb_result  = 32'h10;
      #1;
      check("x0_A", ex_in_A, 0);
      check("x0_valid", ex_valid, 1);
      check("x0_rd_we", ex_rd_we, 0);
      mem_rd_we = 1'b0; wb_rd_we = 1'b0;

      // OR x5,x6,x7 behind a pending load of x7; ADDI waits on decode
      put(OPC_OP, 3'b110, 1'b0, 5'd6, 5'd7, 5'd5, 32'd1, 32'h99, 32'd0, 32'h1c);
      tick();
      put(OPC_OP_IMM, 3'b000, 1'b1, 5'd9, 5'd0, 5'd8, 32'h30, 32'd0, 32'd3, 32'h20);
      mem_rd_we = 1'b1; mem_rd_addr = 5'd7; mem_result = '0; mem_result_ok = 1'b0;
      #1;
      check("lu_valid", ex_valid, 0);
      check("lu_ready", id_ready, 0);
      check("lu_fnc3", ex_fnc3, 3'b110);
      tick();
      mem_result_ok = 1'b1;  mem_result = 32'hABCD;  #1;
`ifdef ALU_OPERAND_FWD_EN
      check("lu_fwd_B", ex_in_B, 32'hABCD);
      check("lu_fwd_valid", ex_valid, 1);
      check("lu_fwd_ready", id_ready, 1);
`else
      check("lu_nofwd_valid", ex_valid, 0);
      mem_rd_we = 1'b0;  #1;
      check("lu_nofwd_B", ex_in_B, 32'h99);
      check("lu_nofwd_valid2", ex_valid, 1);
`endif
      mem_rd_we = 1'b0;
      tick();  id_valid = 1'b0;  #1;
      check("addi_valid", ex_valid, 1);
      check("addi_A", ex_in_A, 32'h30);
      check("addi_B", ex_in_B, 3);
      check("addi_fnc2", ex_fnc2, 0);
      check("addi_rd", ex_rd_addr, 8);

      // Downstream stall for three cycles
      put(OPC_OP, 3'b000, 1'b0, 5'd11, 5'd12, 5'd10, 32'h111, 32'h222, 32'd0, 32'h24);
      tick();
      put(OPC_OP, 3'b000, 1'b1, 5'd13, 5'd14, 5'd15, 32'h333, 32'd1, 32'd0, 32'h28);
      ex_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_ready", id_ready, 0);
         check("stall_A", ex_in_A, 32'h111);
         check("stall_pc", ex_pc, 32'h24);
         tick();
      end
      ex_stall = 1'b0;  #1;
      check("unstall_ready", id_ready, 1);
      check("unstall_A_held", ex_in_A, 32'h111);
      tick();  id_valid = 1'b0;  #1;
      check("post_stall_A", ex_in_A, 32'h333);
      check("post_stall_rd", ex_rd_addr, 15);
      check("post_stall_fnc2", ex_fnc2, 1);

      // Flush wins over stall
      ex_stall = 1'b1;  flush = 1'b1;
      put(OPC_OP, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd9, 32'd9, 32'd0, 32'h2c);
      #1;
      check("flush_ready", id_ready, 1);
      tick();  flush = 1'b0;  id_valid = 1'b0;  #1;
      check("flush_valid", ex_valid, 0);
      check("flush_rd_we", ex_rd_we, 0);
      check("flush_pc", ex_pc, 0);

      // LUI held back by stall, then accepted
      put(OPC_LUI, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'h12345000, 32'h40);
      tick();
      check("lui_stalled_valid", ex_valid, 0);
      ex_stall = 1'b0;
      tick();  id_valid = 1'b0;  #1;
      check("lui_valid", ex_valid, 1);
      check("lui_A", ex_in_A, 0);
      check("lui_B", ex_in_B, 32'h12345000);
      check("lui_pc", ex_pc, 32'h40);
      check("lui_rd_we", ex_rd_we, 1);

      // Reset asserted mid-stall
      ex_stall = 1'b1;
      put(OPC_AUIPC, 3'b000, 1'b0, 5'd0, 5'd0, 5'd2, 32'd0, 32'd0, 32'h1000, 32'h44);
      tick();
      check("midstall_pc", ex_pc, 32'h40);
      rst_n = 1'b0;  #1;
      check("async_rst_valid", ex_valid, 0);
      check("async_rst_B", ex_in_B, 0);
      check("async_rst_pc", ex_pc, 0);
      #1 rst_n = 1'b1;  ex_stall = 1'b0;  id_valid = 1'b0;
      #1 check("post_rst_ready", id_ready, 1);
      tick();

      // SRAI: fnc2 carries bit 30
      put(OPC_OP_IMM, 3'b101, 1'b1, 5'd1, 5'd0, 5'd2, 32'h80, 32'd0, 32'd5, 32'h50);
      tick();  #1;
      check("srai_fnc3", ex_fnc3, 3'b101);
      check("srai_fnc2", ex_fnc2, 1);
      check("srai_A", ex_in_A, 32'h80);
      check("srai_B", ex_in_B, 5);

      // AUIPC uses the PC
      put(OPC_AUIPC, 3'b000, 1'b0, 5'd0, 5'd0, 5'd6, 32'd0, 32'd0, 32'h2000, 32'h100);
      tick();  #1;
      check("auipc_A", ex_in_A, 32'h100);
      check("auipc_B", ex_in_B, 32'h2000);
      check("auipc_rd_we", ex_rd_we, 1);

      // STORE: no writeback, rs2 exported as store data
      put(OPC_STORE, 3'b010, 1'b0, 5'd1, 5'd2, 5'd5, 32'h1000, 32'h77, 32'd8, 32'h104);
      tick();  #1;
      check("store_rd_we", ex_rd_we, 0);
      check("store_A", ex_in_A, 32'h1000);
      check("store_B", ex_in_B, 8);
      check("store_rs2fwd", ex_rs2_fwd, 32'h77);
      check("store_fnc3", ex_fnc3, FNC_ADD_SUB);

      // BRANCH: A is PC, no writeback
      put(OPC_BRANCH, 3'b001, 1'b0, 5'd1, 5'd2, 5'd7, 32'd3, 32'd4, 32'h10, 32'h108);
      tick();  #1;
      check("branch_A", ex_in_A, 32'h108);
      check("branch_rd_we", ex_rd_we, 0);
      check("branch_valid", ex_valid, 1);

      // Unknown opcode
      put(7'b1111111, 3'b111, 1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd6, 32'd9, 32'h10c);
      tick();  id_valid = 1'b0;  #1;
      check("unk_A", ex_in_A, 0);
      check("unk_B", ex_in_B, 0);
      check("unk_fnc3", ex_fnc3, FNC_ADD_SUB);
      check("unk_rd_we", ex_rd_we, 0);

      // Idle decode loads a bubble
      tick();  #1;
      check("idle_valid", ex_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
